alu_top: RTL and testbench

Board-level wrapper around an 8-bit combinational ALU: three push-buttons latch the switch value into operand A, operand B or the opcode register, and the LEDs continuously show the ALU result of the latched values. It sits directly under the FPGA top, between the board I/O (switches, buttons, LEDs) and the arithmetic core.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu.sv | 42 ++++
 rtl/alu_top.sv | 59 +++++
 tb/tb_alu_top.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths and opcode encodings for the switch/button ALU wrapper.
package alu_pkg;

    localparam int unsigned SizeDataDefault = 8;
    localparam int unsigned SizeOpDefault   = 6;
    localparam int unsigned NButtonsDefault = 3;

    // Button bit positions on the board.
    localparam int unsigned BtnLoadA  = 0;
    localparam int unsigned BtnLoadB  = 1;
    localparam int unsigned BtnLoadOp = 2;

    localparam logic [5:0] OpAdd = 6'b100000;
    localparam logic [5:0] OpSub = 6'b100010;
    localparam logic [5:0] OpAnd = 6'b100100;
    localparam logic [5:0] OpOr  = 6'b100101;
    localparam logic [5:0] OpXor = 6'b100110;
    localparam logic [5:0] OpNor = 6'b100111;
    localparam logic [5:0] OpSrl = 6'b000010;
    localparam logic [5:0] OpSra = 6'b000011;

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic, bitwise and shift ops selected by OP;
// unknown opcodes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned SIZEDATA = SizeDataDefault,
    parameter int unsigned SIZEOP   = SizeOpDefault
) (
    input  logic [SIZEDATA-1:0] A,
    input  logic [SIZEDATA-1:0] B,
    input  logic [SIZEOP-1:0]   OP,
    output logic [SIZEDATA-1:0] RESULT
);

    localparam logic [SIZEDATA-1:0] ShiftLimit = SIZEDATA'(SIZEDATA);

    logic                shift_oob;
    logic [SIZEDATA-1:0] srl_res;
    logic [SIZEDATA-1:0] sra_res;

    // Out-of-range shift amounts are clamped explicitly so the result never
    // depends on how a tool treats over-wide shifts.
    assign shift_oob = (B >= ShiftLimit);
    assign srl_res   = shift_oob ? '0 : (A >> B);
    assign sra_res   = shift_oob ? {SIZEDATA{A[SIZEDATA-1]}} : SIZEDATA'($signed(A) >>> B);

    always_comb begin
        RESULT = '0;
        case (OP)
            SIZEOP'(OpAdd): RESULT = A + B;
            SIZEOP'(OpSub): RESULT = A - B;
            SIZEOP'(OpAnd): RESULT = A & B;
            SIZEOP'(OpOr):  RESULT = A | B;
            SIZEOP'(OpXor): RESULT = A ^ B;
            SIZEOP'(OpNor): RESULT = ~(A | B);
            SIZEOP'(OpSrl): RESULT = srl_res;
            SIZEOP'(OpSra): RESULT = sra_res;
            default:        RESULT = '0;
        endcase
    end

endmodule

// File: rtl/alu_top.sv
// Board wrapper: buttons latch the switch value into A, B or the opcode,
// and the LEDs show the ALU result of the latched values.
module alu_top
    import alu_pkg::*;
#(
    parameter int unsigned SIZEDATA  = SizeDataDefault,
    parameter int unsigned SIZEOP    = SizeOpDefault,
    parameter int unsigned N_BUTTONS = NButtonsDefault
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [SIZEDATA-1:0]  SWITCHES,
    input  logic [N_BUTTONS-1:0] BUTTONS,
    output logic [SIZEDATA-1:0]  LEDS
);

    logic [SIZEDATA-1:0] a_q, a_d;
    logic [SIZEDATA-1:0] b_q, b_d;
    logic [SIZEOP-1:0]   op_q, op_d;

    // Buttons are plain level enables; holding one simply reloads each edge.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        op_d = op_q;
        if (BUTTONS[BtnLoadA]) begin
            a_d = SWITCHES;
        end
        if (BUTTONS[BtnLoadB]) begin
            b_d = SWITCHES;
        end
        if (BUTTONS[BtnLoadOp]) begin
            op_d = SWITCHES[SIZEOP-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            op_q <= op_d;
        end
    end

    alu #(
        .SIZEDATA (SIZEDATA),
        .SIZEOP   (SIZEOP)
    ) u_alu (
        .A      (a_q),
        .B      (b_q),
        .OP     (op_q),
        .RESULT (LEDS)
    );

endmodule

// File: tb/tb_alu_top.sv
// Directed bench for alu_top: the driver queues hand-computed LED values and
// a monitor on the falling edge pops and compares them.
module tb_alu_top;

    logic       CLK;
    logic       RESET;
    logic [7:0] SWITCHES;
    logic [2:0] BUTTONS;
    logic [7:0] LEDS;

    int unsigned n_checks;
    int unsigned n_pass;

    logic [7:0] exp_q[$];
    string      name_q[$];

    alu_top #(
        .SIZEDATA  (8),
        .SIZEOP    (6),
        .N_BUTTONS (3)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .SWITCHES (SWITCHES),
        .BUTTONS  (BUTTONS),
        .LEDS     (LEDS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: the wrapper has no valid strobe, so each queued expectation is
    // checked on the next falling edge.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            string      nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (LEDS === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: LEDS=%02h expected %02h", nm, LEDS, e);
            end
        end
    end

    task automatic expect_leds(input logic [7:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One load edge: drive on the falling edge, release buttons after the rise.
    task automatic load(input logic [2:0] btn, input logic [7:0] sw);
        @(negedge CLK);
        SWITCHES = sw;
        BUTTONS  = btn;
        @(posedge CLK);
        #1;
        BUTTONS = 3'b000;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RESET    = 1'b0;
        SWITCHES = 8'hFF;
        BUTTONS  = 3'b111;

        // Reset held with all buttons pressed: nothing may load.
        repeat (2) @(posedge CLK);
        #1;
        expect_leds(8'h00, "reset_hold");
        @(negedge CLK);
        RESET   = 1'b1;
        BUTTONS = 3'b000;
        @(posedge CLK);
        #1;
        expect_leds(8'h00, "reset_release");

        // ADD / SUB wrap.
        load(3'b001, 8'hF0);
        load(3'b010, 8'h20);
        load(3'b100, 8'h20);
        expect_leds(8'h10, "add_wrap");
        load(3'b001, 8'h05);
        load(3'b010, 8'h0A);
        load(3'b100, 8'h22);
        expect_leds(8'hFB, "sub_wrap");

        // Bitwise ops.
        load(3'b001, 8'hCC);
        load(3'b010, 8'hAA);
        load(3'b100, 8'h24);
        expect_leds(8'h88, "and");
        load(3'b100, 8'h25);
        expect_leds(8'hEE, "or");
        load(3'b100, 8'h26);
        expect_leds(8'h66, "xor");
        load(3'b100, 8'h27);
        expect_leds(8'h11, "nor");

        // Shifts, including amounts past the data width.
        load(3'b001, 8'h90);
        load(3'b010, 8'h03);
        load(3'b100, 8'h02);
        expect_leds(8'h12, "srl3");
        load(3'b100, 8'h03);
        expect_leds(8'hF2, "sra3");
        load(3'b010, 8'h09);
        expect_leds(8'hFF, "sra9");
        load(3'b100, 8'h02);
        expect_leds(8'h00, "srl9");

        // Same-cycle visibility, isolation from idle switches, unknown opcode.
        load(3'b001, 8'h01);
        load(3'b010, 8'h02);
        load(3'b100, 8'h20);
        expect_leds(8'h03, "load_latency");
        @(negedge CLK);
        SWITCHES = 8'h7F;
        BUTTONS  = 3'b000;
        repeat (2) @(posedge CLK);
        #1;
        expect_leds(8'h03, "switch_isolation");
        load(3'b100, 8'h3F);
        expect_leds(8'h00, "unknown_op");

        // All three buttons in one edge: A=B=0x24, OP=AND.
        load(3'b111, 8'h24);
        expect_leds(8'h24, "simul_and");
        load(3'b100, 8'h20);
        expect_leds(8'h48, "simul_add");

        // Asynchronous reset mid-operation, with loads attempted meanwhile.
        @(posedge CLK);
        #3;
        RESET    = 1'b0;
        SWITCHES = 8'hFF;
        BUTTONS  = 3'b111;
        #1;
        expect_leds(8'h00, "async_reset");
        @(posedge CLK);
        #1;
        expect_leds(8'h00, "reset_ignores_load");
        @(negedge CLK);
        RESET   = 1'b1;
        BUTTONS = 3'b000;
        @(posedge CLK);
        #1;
        expect_leds(8'h00, "reset_cleared");
        load(3'b100, 8'h20);
        expect_leds(8'h00, "cleared_ab_add");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge CLK);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
